pool_unit: RTL and testbench

//   2x2 stride-2 pooling stage directly downstream of ConvUnit. Consumes the raster-order

---
 rtl/pool_unit_pkg.sv | 26 ++
 rtl/pool_unit_if.sv | 31 +++
 rtl/pool_line_buf.sv | 29 ++
 rtl/pool_unit.sv | 117 +++++++++++
 tb/tb_pool_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/pool_unit_pkg.sv
// Shared constants for the 2x2 stride-2 pooling stage: pooling modes, default
// geometry, and helpers that size the counters and the line buffer.
package pool_unit_pkg;

    localparam int POOL_MAX = 0;
    localparam int POOL_AVG = 1;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_W      = 98;
    localparam int DEF_IMG_H      = 98;

    // Every counter gets at least one bit, even when it only counts to 0 or 1
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // A horizontal pair in average mode carries one extra bit
    function automatic int lb_word_w(input int data_width);
        return data_width + 1;
    endfunction

    localparam int COL_W = cnt_w(DEF_IMG_W);
    localparam int ROW_W = cnt_w(DEF_IMG_H);
    localparam int LB_AW = cnt_w(DEF_IMG_W / 2);

endpackage

// File: rtl/pool_unit_if.sv
// Pixel stream bundle between the convolution stage, the pooling stage and the
// bitmap writer. The master drives pixels in; the slave is the pooling stage.
interface pool_unit_if
    import pool_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  frame_done;

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  valid_out,
        input  frame_done
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output valid_out,
        output frame_done
    );

endinterface

// File: rtl/pool_line_buf.sv
// One-row buffer of horizontal pair results: written while the top row of a
// 2x2 block streams by, read back combinationally while the bottom row does.
module pool_line_buf
    import pool_unit_pkg::*;
#(
    parameter int WIDTH = lb_word_w(DEF_DATA_WIDTH),
    parameter int DEPTH = DEF_IMG_W / 2,
    parameter int AW    = LB_AW
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Contents are deliberately not reset: each entry is written before it is read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pool_unit.sv
// 2x2 stride-2 max/average pooling of a raster-order pixel stream, one pooled
// pixel per block in raster order, no backpressure.
module pool_unit
    import pool_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int POOL_MODE  = POOL_MAX
) (
    input logic       Clk,
    input logic       Rst,
    pool_unit_if.slave bus
);

    localparam int COL_BITS = cnt_w(IMG_W);
    localparam int ROW_BITS = cnt_w(IMG_H);
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_BITS  = cnt_w(LB_DEPTH);
    localparam int HW       = lb_word_w(DATA_WIDTH);

    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_W - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IMG_H - 1);

    generate
        if (IMG_W < 2 || IMG_H < 2) begin : g_bad_geometry
            $error("pool_unit: IMG_W and IMG_H must both be at least 2");
        end
    endgenerate

    logic [COL_BITS-1:0]   col;
    logic [ROW_BITS-1:0]   row;
    logic [DATA_WIDTH-1:0] pair_reg;
    logic [DATA_WIDTH-1:0] pix;
    logic                  pix_valid;
    logic [HW-1:0]         h;
    logic [HW-1:0]         lb_rd;
    logic [DATA_WIDTH-1:0] pooled;
    logic [LB_BITS-1:0]    lb_addr;
    logic                  tail_row;
    logic                  lb_we;

    assign pix       = bus.data_in;
    assign pix_valid = bus.valid_in;
    assign lb_addr   = LB_BITS'(col >> 1);

    // With an odd frame height the final even row has no partner and is skipped
    assign tail_row = ((IMG_H % 2) == 1) && (row == ROW_LAST);
    assign lb_we    = !Rst && pix_valid && col[0] && !row[0] && !tail_row;

    pool_line_buf #(
        .WIDTH (HW),
        .DEPTH (LB_DEPTH),
        .AW    (LB_BITS)
    ) u_line_buf (
        .clk     (Clk),
        .wr_en   (lb_we),
        .wr_addr (lb_addr),
        .wr_data (h),
        .rd_addr (lb_addr),
        .rd_data (lb_rd)
    );

    // Horizontal pair first, then the vertical combine with the buffered top pair
    generate
        if (POOL_MODE == POOL_AVG) begin : g_avg
            logic [DATA_WIDTH+1:0] sum;
            always_comb begin
                h      = {1'b0, pair_reg} + {1'b0, pix};
                sum    = {1'b0, lb_rd} + {1'b0, h};
                pooled = DATA_WIDTH'(sum >> 2);
            end
        end else begin : g_max
            logic [HW-1:0] vmax;
            always_comb begin
                h      = (pix > pair_reg) ? {1'b0, pix} : {1'b0, pair_reg};
                vmax   = (lb_rd > h) ? lb_rd : h;
                pooled = DATA_WIDTH'(vmax);
            end
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Rst) begin
            col            <= '0;
            row            <= '0;
            pair_reg       <= '0;
            bus.data_out   <= '0;
            bus.valid_out  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.valid_out  <= 1'b0;
            bus.frame_done <= 1'b0;
            if (pix_valid) begin
                if (!col[0]) begin
                    pair_reg <= pix;
                end else if (row[0]) begin
                    bus.data_out  <= pooled;
                    bus.valid_out <= 1'b1;
                end

                if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        row            <= '0;
                        bus.frame_done <= 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_unit.sv
// Directed bench for pool_unit: 4x4 max and average instances plus a 5x3 max
// instance with odd geometry, all on one clock and one reset.
module tb_pool_unit;
    import pool_unit_pkg::*;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_max[$];
    logic [7:0] q_avg[$];
    logic [7:0] q_odd[$];
    int fd_max = 0;
    int fd_avg = 0;
    int fd_odd = 0;
    int dbl_max = 0;
    logic prev_vo_max = 1'b0;

    pool_unit_if #(.DATA_WIDTH(8)) if_max ();
    pool_unit_if #(.DATA_WIDTH(8)) if_avg ();
    pool_unit_if #(.DATA_WIDTH(8)) if_odd ();

    pool_unit #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4), .POOL_MODE(POOL_MAX)) u_max (
        .Clk (clk),
        .Rst (rst),
        .bus (if_max)
    );

    pool_unit #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4), .POOL_MODE(POOL_AVG)) u_avg (
        .Clk (clk),
        .Rst (rst),
        .bus (if_avg)
    );

    pool_unit #(.DATA_WIDTH(8), .IMG_W(5), .IMG_H(3), .POOL_MODE(POOL_MAX)) u_odd (
        .Clk (clk),
        .Rst (rst),
        .bus (if_odd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Outputs only move on the rising edge, so the falling edge is a quiet sample point
    always @(negedge clk) begin
        if (if_max.valid_out) q_max.push_back(if_max.data_out);
        if (if_avg.valid_out) q_avg.push_back(if_avg.data_out);
        if (if_odd.valid_out) q_odd.push_back(if_odd.data_out);
        if (if_max.frame_done) fd_max++;
        if (if_avg.frame_done) fd_avg++;
        if (if_odd.frame_done) fd_odd++;
        if (if_max.valid_out && prev_vo_max) dbl_max++;
        prev_vo_max = if_max.valid_out;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input int sel, input int idx);
        logic [7:0] v;
        v = 'x;
        case (sel)
            0: if (idx < q_max.size()) v = q_max[idx];
            1: if (idx < q_avg.size()) v = q_avg[idx];
            default: if (idx < q_odd.size()) v = q_odd[idx];
        endcase
        return v;
    endfunction

    function automatic int q_size(input int sel);
        case (sel)
            0: return q_max.size();
            1: return q_avg.size();
            default: return q_odd.size();
        endcase
    endfunction

    task automatic check_output(input string tag, input int sel, input int n,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp [4];
        exp = '{e0, e1, e2, e3};
        check_val({tag, "_count"}, 32'(q_size(sel)), 32'(n));
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_out%0d", tag, i), 32'(q_at(sel, i)), 32'(exp[i]));
        end
    endtask

    task automatic clear_log();
        q_max.delete();
        q_avg.delete();
        q_odd.delete();
        fd_max  = 0;
        fd_avg  = 0;
        fd_odd  = 0;
        dbl_max = 0;
    endtask

    task automatic drive_px(input logic [2:0] mask, input logic [7:0] px);
        @(negedge clk);
        if_max.valid_in = mask[0];
        if_avg.valid_in = mask[1];
        if_odd.valid_in = mask[2];
        if_max.data_in  = px;
        if_avg.data_in  = px;
        if_odd.data_in  = px;
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            if_max.valid_in = 1'b0;
            if_avg.valid_in = 1'b0;
            if_odd.valid_in = 1'b0;
        end
    endtask

    // Pixel i of the run is first + i*step; gap idle cycles follow every pixel
    task automatic apply_stimulus(input logic [2:0] mask, input int n, input int first,
                                  input int step, input int gap);
        for (int i = 0; i < n; i++) begin
            drive_px(mask, 8'(first + i * step));
            if (gap > 0) drive_idle(gap);
        end
    endtask

    initial begin
        rst = 1'b1;
        if_max.valid_in = 1'b0;
        if_avg.valid_in = 1'b0;
        if_odd.valid_in = 1'b0;
        if_max.data_in  = '0;
        if_avg.data_in  = '0;
        if_odd.data_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_max_valid", 32'(if_max.valid_out), 32'd0);
        check_val("rst_max_data", 32'(if_max.data_out), 32'd0);
        check_val("rst_max_done", 32'(if_max.frame_done), 32'd0);
        check_val("rst_avg_valid", 32'(if_avg.valid_out), 32'd0);
        check_val("rst_avg_data", 32'(if_avg.data_out), 32'd0);
        check_val("rst_odd_valid", 32'(if_odd.valid_out), 32'd0);
        check_val("rst_odd_done", 32'(if_odd.frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle(2);

        $display("[TB] 4x4 frame 1..16 into max and avg");
        clear_log();
        apply_stimulus(3'b011, 16, 1, 1, 0);
        @(posedge clk);
        #1;
        check_val("s1_done_pulse_max", 32'(if_max.frame_done), 32'd1);
        check_val("s2_done_pulse_avg", 32'(if_avg.frame_done), 32'd1);
        drive_idle(4);
        check_output("s1_max", 0, 4, 8'd6, 8'd8, 8'd14, 8'd16);
        check_output("s2_avg", 1, 4, 8'd3, 8'd5, 8'd11, 8'd13);
        check_val("s1_done_count", 32'(fd_max), 32'd1);
        check_val("s2_done_count", 32'(fd_avg), 32'd1);

        $display("[TB] saturated and zero frames");
        clear_log();
        apply_stimulus(3'b010, 16, 255, 0, 0);
        drive_idle(4);
        check_output("s3_avg_ff", 1, 4, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        apply_stimulus(3'b001, 16, 0, 0, 0);
        drive_idle(4);
        check_output("s3_max_zero", 0, 4, 8'd0, 8'd0, 8'd0, 8'd0);

        $display("[TB] gapped input");
        clear_log();
        apply_stimulus(3'b001, 16, 1, 1, 3);
        drive_idle(4);
        check_output("s4_gap", 0, 4, 8'd6, 8'd8, 8'd14, 8'd16);
        check_val("s4_double_pulse", 32'(dbl_max), 32'd0);
        check_val("s4_done_count", 32'(fd_max), 32'd1);

        $display("[TB] reset mid-frame");
        apply_stimulus(3'b001, 6, 1, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        if_max.valid_in = 1'b1;
        if_max.data_in  = 8'd99;
        @(posedge clk);
        #1;
        check_val("s5_pending_cleared", 32'(if_max.valid_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        if_max.valid_in = 1'b0;
        clear_log();
        apply_stimulus(3'b001, 16, 1, 1, 0);
        drive_idle(4);
        check_output("s5_after_rst", 0, 4, 8'd6, 8'd8, 8'd14, 8'd16);
        check_val("s5_done_count", 32'(fd_max), 32'd1);

        $display("[TB] 5x3 odd geometry");
        clear_log();
        apply_stimulus(3'b100, 15, 1, 1, 0);
        @(posedge clk);
        #1;
        check_val("s6_done_pulse", 32'(if_odd.frame_done), 32'd1);
        drive_idle(4);
        check_output("s6_single", 2, 2, 8'd7, 8'd9, 8'd0, 8'd0);
        clear_log();
        apply_stimulus(3'b100, 15, 1, 1, 0);
        apply_stimulus(3'b100, 15, 1, 1, 0);
        drive_idle(4);
        check_output("s6_double", 2, 4, 8'd7, 8'd9, 8'd7, 8'd9);
        check_val("s6_done_count", 32'(fd_odd), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
